// File: rtl/piso_shift_register_165.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// piso_shift_register_165
//
// Parallel-in / serial-out shift register in the style of the 74LS165, with a
// shift counter and a done flag for framing serial words.
//
// A WIDTH-bit word is loaded synchronously (sh_ld_n = 0) and then shifted out
// MSB-first on q_h, one bit per rising clk edge while sh_ld_n = 1 and
// clk_inh = 0. Serial input ser enters at stage A (LSB end). Load overrides
// clock inhibit, as on the original part.
//
// Optional build macro: PROPAGATION_DELAY_EN
//   defined   : q_h, q_h_n, bit_cnt and done are driven through #DELAY ns
//               continuous assigns (simulation gate-delay flavour).
//   undefined : zero-delay outputs, synthesizable as-is.
//
// Parameters
//   DELAY   output propagation delay in ns (delay build only)
//   WIDTH   register length in bits, 2..32
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   sh_ld_n  in   0 = parallel load, 1 = shift
//   clk_inh  in   1 = hold register, counter and state
//   ser      in   serial data into stage A
//   d        in   parallel data, d[WIDTH-1] is the first bit out
//   q_h      out  last stage (register bit WIDTH-1)
//   q_h_n    out  complement of q_h
//   bit_cnt  out  shifts completed since the last load (saturates at WIDTH)
//   done     out  high once WIDTH shifts have completed since the last load
// -----------------------------------------------------------------------------
module piso_shift_register_165 #(
    parameter int DELAY = 10,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       sh_ld_n,
    input  logic                       clk_inh,
    input  logic                       ser,
    input  logic [WIDTH-1:0]           d,
    output logic                       q_h,
    output logic                       q_h_n,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // Counter reference values sized to the counter width.
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    // Elaboration-time guard on the supported parameter space.
    if (WIDTH < 2 || WIDTH > 32 || DELAY < 0) begin : g_param_check
        $error("piso_shift_register_165: WIDTH must be 2..32 and DELAY >= 0");
    end

    // Word-framing state machine.
    //   EMPTY  : after reset, data shifts but nothing is counted
    //   LOADED : word in flight, counting shifts
    //   LAST   : final data bit is on q_h
    //   DONE   : word complete, counter saturated
    typedef enum logic [1:0] {
        ST_EMPTY  = 2'b00,
        ST_LOADED = 2'b01,
        ST_LAST   = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   shift_r;
    logic               q_h_n_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               done_r;

    // Counter increment, kept as a helper so the width handling lives in one place.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] value);
        cnt_inc = value + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Shift register, complementary output, counter, flag and state machine.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_r <= {WIDTH{1'b0}};
            q_h_n_r <= 1'b1;
            cnt_r   <= CNT_ZERO;
            done_r  <= 1'b0;
            state_r <= ST_EMPTY;
        end else if (!sh_ld_n) begin
            // Load wins over inhibit and restarts the word from any state.
            shift_r <= d;
            q_h_n_r <= ~d[WIDTH-1];
            cnt_r   <= CNT_ZERO;
            done_r  <= 1'b0;
            state_r <= ST_LOADED;
        end else if (!clk_inh) begin
            shift_r <= {shift_r[WIDTH-2:0], ser};
            // q_h_n is kept as its own flop, tracking the bit about to reach stage H.
            q_h_n_r <= ~shift_r[WIDTH-2];
            case (state_r)
                ST_EMPTY: begin
                    cnt_r   <= CNT_ZERO;
                    done_r  <= 1'b0;
                    state_r <= ST_EMPTY;
                end
                ST_LOADED: begin
                    cnt_r  <= cnt_inc(cnt_r);
                    done_r <= 1'b0;
                    if (cnt_inc(cnt_r) == CNT_LAST) begin
                        state_r <= ST_LAST;
                    end else begin
                        state_r <= ST_LOADED;
                    end
                end
                ST_LAST: begin
                    cnt_r   <= CNT_FULL;
                    done_r  <= 1'b1;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    cnt_r   <= CNT_FULL;
                    done_r  <= 1'b1;
                    state_r <= ST_DONE;
                end
                default: begin
                    // Unreachable encoding: fall back to the idle framing state.
                    cnt_r   <= CNT_ZERO;
                    done_r  <= 1'b0;
                    state_r <= ST_EMPTY;
                end
            endcase
        end else begin
            // Clock inhibit: everything holds.
            shift_r <= shift_r;
            q_h_n_r <= q_h_n_r;
            cnt_r   <= cnt_r;
            done_r  <= done_r;
            state_r <= state_r;
        end
    end

`ifdef PROPAGATION_DELAY_EN
    assign #DELAY q_h     = shift_r[WIDTH-1];
    assign #DELAY q_h_n   = q_h_n_r;
    assign #DELAY bit_cnt = cnt_r;
    assign #DELAY done    = done_r;
`else
    assign q_h     = shift_r[WIDTH-1];
    assign q_h_n   = q_h_n_r;
    assign bit_cnt = cnt_r;
    assign done    = done_r;
`endif

endmodule

// File: tb/tb_piso_shift_register_165.sv
`timescale 1ns/1ps
// Scoreboard bench for piso_shift_register_165 (WIDTH = 8, zero-delay build).
// The driver applies one directed vector per clock and queues the expected
// outputs; the monitor pops and compares on every falling clk edge.
module tb_piso_shift_register_165;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk;
    logic             reset_n;
    logic             sh_ld_n;
    logic             clk_inh;
    logic             ser;
    logic [WIDTH-1:0] d;
    logic             q_h;
    logic             q_h_n;
    logic [CW-1:0]    bit_cnt;
    logic             done;

    typedef struct {
        string         name;
        logic          q;
        logic          qn;
        logic [CW-1:0] cnt;
        logic          dn;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    piso_shift_register_165 #(.DELAY(10), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sh_ld_n (sh_ld_n),
        .clk_inh (clk_inh),
        .ser     (ser),
        .d       (d),
        .q_h     (q_h),
        .q_h_n   (q_h_n),
        .bit_cnt (bit_cnt),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue an expectation; q_h_n is expected as the complement of q_h.
    task automatic expect_out(input string nm, input logic eq, input int ec, input logic ed);
        exp_t e;
        e.name = nm;
        e.q    = eq;
        e.qn   = ~eq;
        e.cnt  = CW'(ec);
        e.dn   = ed;
        exp_q.push_back(e);
    endtask

    // Called just after a falling edge: drive, clock once, queue expectation.
    task automatic step(input logic ld_n, input logic inh, input logic s,
                        input logic [WIDTH-1:0] dv, input string nm,
                        input logic eq, input int ec, input logic ed);
        sh_ld_n = ld_n;
        clk_inh = inh;
        ser     = s;
        d       = dv;
        @(posedge clk);
        #1;
        expect_out(nm, eq, ec, ed);
        @(negedge clk);
    endtask

    // Monitor: compare every queued expectation on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks = checks + 1;
            if (q_h !== e.q) begin
                errors = errors + 1;
                $display("FAIL %s q_h: got %b expected %b", e.name, q_h, e.q);
            end
            checks = checks + 1;
            if (q_h_n !== e.qn) begin
                errors = errors + 1;
                $display("FAIL %s q_h_n: got %b expected %b", e.name, q_h_n, e.qn);
            end
            checks = checks + 1;
            if (bit_cnt !== e.cnt) begin
                errors = errors + 1;
                $display("FAIL %s bit_cnt: got %0d expected %0d", e.name, bit_cnt, e.cnt);
            end
            checks = checks + 1;
            if (done !== e.dn) begin
                errors = errors + 1;
                $display("FAIL %s done: got %b expected %b", e.name, done, e.dn);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Hand-computed q_h sequences.
    logic [7:0] a5_seq;   // after shifts 1..8 of 8'hA5, ser = 0
    logic [3:0] c3_pre;   // after shifts 1..3 of 8'hC3
    logic [4:0] c3_post;  // after shifts 4..8 of 8'hC3, ser = 0

    initial begin
        a5_seq  = 8'b0_1_0_0_1_0_1_0;  // index k-1 = value after shift k (LSB first)
        a5_seq  = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        c3_pre  = 4'b0_0_0_1;          // bit0 = shift 1 (1), bit1 = shift 2 (0), bit2 = shift 3 (0)
        c3_post = 5'b0_1_1_0_0;        // shifts 4..8: 0,0,1,1,0

        reset_n = 1'b0;
        sh_ld_n = 1'b1;
        clk_inh = 1'b0;
        ser     = 1'b0;
        d       = 8'h00;
        #1;
        expect_out("reset", 1'b0, 0, 1'b0);
        #19;                            // t = 20, falling edge
        reset_n = 1'b1;

        // 1. load A5
        step(1'b0, 1'b0, 1'b0, 8'hA5, "load_a5", 1'b1, 0, 1'b0);

        // 2. shift the full word out, then one saturating shift
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, $sformatf("a5_shift%0d", k),
                 a5_seq[k-1], k, (k == 8) ? 1'b1 : 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 8'h00, "a5_saturate", 1'b0, 8, 1'b1);

        // 3. clock inhibit mid-word (load from DONE also restarts the word)
        step(1'b0, 1'b0, 1'b0, 8'hC3, "load_c3", 1'b1, 0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, $sformatf("c3_shift%0d", k), c3_pre[k-1], k, 1'b0);
        end
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 1'b1, 1'b1, 8'hFF, $sformatf("c3_inhibit%0d", k), 1'b0, 3, 1'b0);
        end
        for (int k = 4; k <= 8; k++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, $sformatf("c3_resume%0d", k), c3_post[k-4], k,
                 (k == 8) ? 1'b1 : 1'b0);
        end

        // 4. mid-word reload with inhibit asserted
        step(1'b0, 1'b0, 1'b0, 8'hFF, "load_ff", 1'b1, 0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, $sformatf("ff_shift%0d", k), 1'b1, k, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0, 8'h01, "load_01_over_inh", 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h00, "hold_01", 1'b0, 0, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, $sformatf("x01_shift%0d", k),
                 (k == 7) ? 1'b1 : 1'b0, k, 1'b0);
        end

        // 5. saturation with ser = 1, then asynchronous reset
        step(1'b0, 1'b0, 1'b1, 8'h80, "load_80", 1'b1, 0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, 1'b0, 1'b1, 8'h00, $sformatf("x80_shift%0d", k),
                 (k >= 8) ? 1'b1 : 1'b0, (k >= 8) ? 8 : k, (k >= 8) ? 1'b1 : 1'b0);
        end
        @(posedge clk);
        #3;
        reset_n = 1'b0;                // no clock edge before the next compare
        #1;
        expect_out("async_reset", 1'b0, 0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // EMPTY state: data shifts but nothing is counted
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0, 1'b1, 8'h00, $sformatf("empty_shift%0d", k),
                 (k == 8) ? 1'b1 : 1'b0, 0, 1'b0);
        end

        // Drain the scoreboard with a bounded wait.
        #1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
